// File: rtl/pdm_cic_array.sv
// Multichannel PDM-to-PCM decimator: per-channel 3rd-order CIC integrators feeding
// a shared, time-multiplexed comb engine that streams one PCM sample per channel per frame.
module pdm_cic_array #(
    parameter int CH    = 96,
    parameter int DEC   = 64,
    parameter int OUT_W = 16,
    localparam int W    = 3 * $clog2(DEC) + 2,
    localparam int CW   = $clog2(CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pdm_en,
    input  logic [CH-1:0]    pdm,
    output logic [OUT_W-1:0] pcm_data,
    output logic [CW-1:0]    pcm_ch,
    output logic             pcm_valid,
    input  logic             pcm_ready,
    output logic             pcm_last,
    output logic             busy,
    output logic             overrun
);

    localparam int DW = $clog2(DEC);

    // Output handshake: a sample is transferred on any rising edge where
    // pcm_valid && pcm_ready; while pcm_valid is high and pcm_ready is low,
    // pcm_data/pcm_ch/pcm_last hold and pcm_valid stays high.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     i1_q [CH];
    logic [W-1:0]     i1_d [CH];
    logic [W-1:0]     i2_q [CH];
    logic [W-1:0]     i2_d [CH];
    logic [W-1:0]     i3_q [CH];
    logic [W-1:0]     i3_d [CH];
    logic [W-1:0]     s_q  [CH];
    logic [W-1:0]     s_d  [CH];
    logic [W-1:0]     d1_q [CH];
    logic [W-1:0]     d1_d [CH];
    logic [W-1:0]     d2_q [CH];
    logic [W-1:0]     d2_d [CH];
    logic [W-1:0]     d3_q [CH];
    logic [W-1:0]     d3_d [CH];
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic [CW-1:0]    ptr_q, ptr_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;
    logic [OUT_W-1:0] pcm_data_q, pcm_data_d;
    logic [CW-1:0]    pcm_ch_q, pcm_ch_d;
    logic             pcm_last_q, pcm_last_d;

    logic             frame_tick;
    logic             ptr_last;
    logic [W-1:0]     s_p, c1, c2, c3;

    assign frame_tick = pdm_en && (dcnt_q == DW'(DEC - 1));
    assign ptr_last   = (ptr_q == CW'(CH - 1));

    assign pcm_valid = (state_q == PRESENT);
    assign pcm_data  = pcm_data_q;
    assign pcm_ch    = pcm_ch_q;
    assign pcm_last  = pcm_last_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

    // Integrators run every pdm_en regardless of engine state.
    always_comb begin
        logic [W-1:0] x, n1, n2, n3;
        x  = '0;
        n1 = '0;
        n2 = '0;
        n3 = '0;
        for (int c = 0; c < CH; c++) begin
            x       = pdm[c] ? W'(1) : {W{1'b1}};
            n1      = i1_q[c] + x;
            n2      = i2_q[c] + n1;
            n3      = i3_q[c] + n2;
            i1_d[c] = pdm_en ? n1 : i1_q[c];
            i2_d[c] = pdm_en ? n2 : i2_q[c];
            i3_d[c] = pdm_en ? n3 : i3_q[c];
        end
        dcnt_d = pdm_en ? dcnt_q + DW'(1) : dcnt_q;
    end

    // Comb differences for the channel under the engine pointer.
    assign s_p = s_q[ptr_q];
    assign c1  = s_p - d1_q[ptr_q];
    assign c2  = c1 - d2_q[ptr_q];
    assign c3  = c2 - d3_q[ptr_q];

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        overrun_d  = overrun_q;
        ptr_d      = ptr_q;
        pcm_data_d = pcm_data_q;
        pcm_ch_d   = pcm_ch_q;
        pcm_last_d = pcm_last_q;
        s_d        = s_q;
        d1_d       = d1_q;
        d2_d       = d2_q;
        d3_d       = d3_q;

        // busy_q is still high on the final-accept cycle, so a coincident boundary is dropped.
        if (frame_tick) begin
            if (busy_q) begin
                overrun_d = 1'b1;
            end else begin
                busy_d = 1'b1;
                ptr_d  = '0;
                for (int c = 0; c < CH; c++) s_d[c] = i3_d[c];
            end
        end

        case (state_q)
            IDLE: begin
                if (busy_q) state_d = LOAD;
            end
            LOAD: begin
                pcm_data_d = OUT_W'($signed(c3) >>> (W - OUT_W));
                pcm_ch_d   = ptr_q;
                pcm_last_d = ptr_last;
                state_d    = PRESENT;
            end
            PRESENT: begin
                if (pcm_ready) begin
                    d1_d[ptr_q] = s_p;
                    d2_d[ptr_q] = c1;
                    d3_d[ptr_q] = c2;
                    if (ptr_last) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        ptr_d   = ptr_q + CW'(1);
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            dcnt_q     <= '0;
            ptr_q      <= '0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            pcm_data_q <= '0;
            pcm_ch_q   <= '0;
            pcm_last_q <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                i1_q[c] <= '0;
                i2_q[c] <= '0;
                i3_q[c] <= '0;
                s_q[c]  <= '0;
                d1_q[c] <= '0;
                d2_q[c] <= '0;
                d3_q[c] <= '0;
            end
        end else begin
            state_q    <= state_d;
            dcnt_q     <= dcnt_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
            pcm_data_q <= pcm_data_d;
            pcm_ch_q   <= pcm_ch_d;
            pcm_last_q <= pcm_last_d;
            for (int c = 0; c < CH; c++) begin
                i1_q[c] <= i1_d[c];
                i2_q[c] <= i2_d[c];
                i3_q[c] <= i3_d[c];
                s_q[c]  <= s_d[c];
                d1_q[c] <= d1_d[c];
                d2_q[c] <= d2_d[c];
                d3_q[c] <= d3_d[c];
            end
        end
    end

endmodule

// File: tb/tb_pdm_cic_array.sv
// Bench for pdm_cic_array: random and patterned PDM stimulus compared against a
// full-precision per-channel CIC reference and an expected-sample queue.
module tb_pdm_cic_array;

    localparam int CH    = 96;
    localparam int DEC   = 64;
    localparam int OUT_W = 16;
    localparam int W     = 20;
    localparam int CW    = 7;
    localparam int EW    = 1 + CW + OUT_W;

    logic             clk;
    logic             rst;
    logic             pdm_en;
    logic [CH-1:0]    pdm;
    logic [OUT_W-1:0] pcm_data;
    logic [CW-1:0]    pcm_ch;
    logic             pcm_valid;
    logic             pcm_ready;
    logic             pcm_last;
    logic             busy;
    logic             overrun;

    pdm_cic_array #(.CH(CH), .DEC(DEC), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .pdm_en    (pdm_en),
        .pdm       (pdm),
        .pcm_data  (pcm_data),
        .pcm_ch    (pcm_ch),
        .pcm_valid (pcm_valid),
        .pcm_ready (pcm_ready),
        .pcm_last  (pcm_last),
        .busy      (busy),
        .overrun   (overrun)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: unbounded integrators and comb delays per channel
    longint i1_m [CH];
    longint i2_m [CH];
    longint i3_m [CH];
    longint d1_m [CH];
    longint d2_m [CH];
    longint d3_m [CH];

    logic [EW-1:0]    exp_q[$];
    int               frm_q[$];
    int               en_count, frame_no, edge_no, snap_edge;
    bit               lat_armed, lat_pending, ovr_m;
    bit               stall;
    logic [OUT_W-1:0] held_data;
    logic [CW-1:0]    held_ch;
    logic             held_last;
    int               mode;
    int               n_checks, n_fails;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            i1_m[c] = 0; i2_m[c] = 0; i3_m[c] = 0;
            d1_m[c] = 0; d2_m[c] = 0; d3_m[c] = 0;
        end
        exp_q.delete();
        frm_q.delete();
        en_count    = 0;
        frame_no    = 0;
        ovr_m       = 0;
        stall       = 0;
        lat_armed   = 1;
        lat_pending = 0;
    endtask

    task automatic take_snapshot();
        longint c1, c2, c3;
        logic signed [W-1:0] cw;
        logic [OUT_W-1:0] v;
        frame_no++;
        for (int c = 0; c < CH; c++) begin
            c1 = i3_m[c] - d1_m[c];
            c2 = c1 - d2_m[c];
            c3 = c2 - d3_m[c];
            d1_m[c] = i3_m[c];
            d2_m[c] = c1;
            d3_m[c] = c2;
            cw = c3[W-1:0];
            v  = OUT_W'(cw >>> (W - OUT_W));
            exp_q.push_back({(c == CH - 1), CW'(c), v});
            frm_q.push_back(frame_no);
        end
        if (lat_armed) begin
            snap_edge   = edge_no;
            lat_pending = 1;
            lat_armed   = 0;
        end
    endtask

    function automatic logic [OUT_W-1:0] const_exp(input int m, input int ch);
        logic signed [OUT_W-1:0] v;
        case (m)
            1:       v = 16384;
            2:       v = (ch % 2 == 1) ? 16384 : -16384;
            default: v = 0;
        endcase
        return v;
    endfunction

    // Apply what the coming rising edge does, given the inputs just driven.
    task automatic model_edge(input logic en, input logic [CH-1:0] bits, input logic rdy);
        logic [EW-1:0] e;
        int f;
        bit busy_before;
        busy_before = (exp_q.size() != 0);
        if (pcm_valid && rdy) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_sample", {25'b0, pcm_ch}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                f = frm_q.pop_front();
                check_eq("pcm_data", {16'b0, pcm_data}, {16'b0, e[OUT_W-1:0]});
                check_eq("pcm_ch", {25'b0, pcm_ch}, {25'b0, e[OUT_W +: CW]});
                check_eq("pcm_last", {31'b0, pcm_last}, {31'b0, e[EW-1]});
                if (mode >= 1 && mode <= 3 && f >= 4)
                    check_eq("steady_value", {16'b0, pcm_data}, {16'b0, const_exp(mode, int'(pcm_ch))});
            end
        end
        stall     = pcm_valid && !rdy;
        held_data = pcm_data;
        held_ch   = pcm_ch;
        held_last = pcm_last;
        if (en) begin
            for (int c = 0; c < CH; c++) begin
                i1_m[c] += bits[c] ? 1 : -1;
                i2_m[c] += i1_m[c];
                i3_m[c] += i2_m[c];
            end
            if (en_count % DEC == DEC - 1) begin
                if (busy_before) ovr_m = 1;
                else             take_snapshot();
            end
            en_count++;
        end
    endtask

    task automatic post_checks();
        check_eq("busy", {31'b0, busy}, {31'b0, (exp_q.size() != 0)});
        check_eq("overrun", {31'b0, overrun}, {31'b0, ovr_m});
        if (stall) begin
            check_eq("stall_valid", {31'b0, pcm_valid}, 32'd1);
            check_eq("stall_data", {16'b0, pcm_data}, {16'b0, held_data});
            check_eq("stall_ch", {25'b0, pcm_ch}, {25'b0, held_ch});
            check_eq("stall_last", {31'b0, pcm_last}, {31'b0, held_last});
        end
        if (lat_pending && pcm_valid) begin
            check_eq("first_latency", 32'(edge_no - snap_edge), 32'd2);
            lat_pending = 0;
        end
    endtask

    // driver: called and returns at a falling edge
    task automatic run_cycle(input logic en, input logic [CH-1:0] bits, input logic rdy);
        pdm_en    = en;
        pdm       = bits;
        pcm_ready = rdy;
        edge_no++;
        model_edge(en, bits, rdy);
        @(negedge clk);
        post_checks();
    endtask

    function automatic logic [CH-1:0] gen_bits(input int m);
        logic [CH-1:0] b;
        case (m)
            1: b = '1;
            2: for (int c = 0; c < CH; c++) b[c] = (c % 2 == 1);
            3: b = (en_count % 2 == 0) ? '1 : '0;
            default: b = {$urandom(), $urandom(), $urandom()};
        endcase
        return b;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, {31'b0, pcm_valid}, 32'd0);
        check_eq({tag, "_data"}, {16'b0, pcm_data}, 32'd0);
        check_eq({tag, "_ch"}, {25'b0, pcm_ch}, 32'd0);
        check_eq({tag, "_last"}, {31'b0, pcm_last}, 32'd0);
        check_eq({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check_eq({tag, "_overrun"}, {31'b0, overrun}, 32'd0);
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        pdm_en    = 1'b0;
        pdm       = '0;
        pcm_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        model_reset();
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            run_cycle(1'b0, '0, 1'b1);
            guard++;
        end
        check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_test(input int m, input int period, input bit rand_rdy, input int frames);
        logic rdy;
        mode = m;
        for (int c = 0; c < frames * DEC * period; c++) begin
            rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            run_cycle((c % period) == period - 1, gen_bits(m), rdy);
        end
        drain();
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        edge_no  = 0;
        mode     = 0;
        rst       = 1'b0;
        pdm_en    = 1'b0;
        pdm       = '0;
        pcm_ready = 1'b0;
        @(negedge clk);

        do_reset();
        run_test(1, 4, 1'b0, 6);          // all ones

        do_reset();
        run_test(2, 4, 1'b0, 6);          // odd channels 1, even 0

        do_reset();
        run_test(3, 4, 1'b0, 6);          // alternating 1010...

        do_reset();
        run_test(4, 8, 1'b1, 6);          // random data, random backpressure
        check_eq("no_overrun", {31'b0, overrun}, 32'd0);

        do_reset();
        run_test(4, 1, 1'b0, 6);          // pdm_en every clk
        check_eq("overrun_sticky", {31'b0, overrun}, 32'd1);

        // reset in the middle of a drain, then a cold restart
        do_reset();
        mode = 4;
        begin
            bit hit;
            hit = 0;
            for (int c = 0; c < 4 * DEC * 4 && !hit; c++) begin
                run_cycle((c % 4) == 3, gen_bits(4), 1'b1);
                if (frame_no >= 2 && pcm_valid && pcm_ch == CW'(40)) hit = 1;
            end
            check_eq("reached_ch40", {31'b0, hit}, 32'd1);
            rst = 1'b0;
            #1;
            check_reset_outputs("midreset");
            @(negedge clk);
            rst = 1'b1;
            model_reset();
        end
        run_test(4, 4, 1'b0, 5);

        $display("test done: total=%0d bad=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/pdm_cic_array.md
# pdm_cic_array

Multichannel PDM-to-PCM decimator for the microphone array: one 3rd-order CIC filter per channel, with parallel per-channel integrators and a single time-multiplexed comb engine. Once per decimation frame, every channel's PCM sample is streamed out in channel order over a valid/ready interface. It sits between the PDM capture shift registers and the beamforming/PCM consumers, and replaces the per-channel `top_pdm` instances.

## Interface
Parameters:
- `CH`, 96, number of PDM channels.
- `DEC`, 64, decimation ratio; must be a power of two, ≥ 4.
- `OUT_W`, 16, output sample width; must be ≤ `W`.
- Derived: `W = 3*log2(DEC) + 2` (internal signed width; 20 at defaults). `CW = $clog2(CH)`.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `pdm_en` in 1: PDM sample strobe; `pdm` is consumed only on cycles where this is high.
- `pdm` in CH: one PDM bit per channel; bit i belongs to channel i.
- `pcm_data` out OUT_W: signed PCM sample.
- `pcm_ch` out CW: channel index of `pcm_data`.
- `pcm_valid` out 1: output sample is presented.
- `pcm_ready` in 1: consumer accepts the sample.
- `pcm_last` out 1: high with the channel CH-1 sample.
- `busy` out 1: a frame is being drained.
- `overrun` out 1: sticky; cleared only by reset.

## Operation
- Input mapping: PDM bit 1 → +1, bit 0 → −1 (W-bit signed).
- Integrators: each channel has I1, I2, I3, W-bit, wrapping two's complement.
  - Updated only when `pdm_en`=1: I1+=x; I2+=I1_new; I3+=I2_new.
- Decimation counter: `dcnt` runs 0..DEC-1 and advances on each `pdm_en`. A frame boundary is `pdm_en` high with `dcnt`=DEC-1; `dcnt` then wraps to 0.
- Frame boundary while idle (`busy`=0):
  - Snapshot bank S[ch] ← next-state I3 of every channel, i.e. including this cycle's update.
  - `busy`←1 and the engine pointer ←0.
- Frame boundary while `busy`=1: the frame is dropped, S is untouched, and `overrun`←1. Comb state is not advanced, so the next output frame contains a transient; this is accepted behaviour.
- Comb engine, FSM states IDLE, LOAD, PRESENT:
  - IDLE: waits for a snapshot, then goes to LOAD.
  - LOAD, one cycle: for channel p it computes c1=S[p]−D1[p], c2=c1−D2[p], c3=c2−D3[p], all W-bit wrapping.
    - Registers `pcm_data` = c3 >>> (W−OUT_W), arithmetic shift, no rounding.
    - Registers `pcm_ch`=p and `pcm_last`=(p==CH-1), then goes to PRESENT.
  - PRESENT: `pcm_valid`=1. `pcm_data`, `pcm_ch` and `pcm_last` stay stable until `pcm_valid`&&`pcm_ready`.
    - On accept: D1[p]←S[p], D2[p]←c1, D3[p]←c2.
    - If p<CH-1: p←p+1 and go to LOAD.
    - Otherwise: `busy`←0 and go to IDLE.
- Integrators and `dcnt` keep running regardless of engine state or backpressure.
- Gain: DC full scale gives c3=±DEC³. With the shift, all-ones gives +2^(3log2(DEC)+OUT_W−W) = +16384 at defaults, and all-zeros gives −16384.

## Timing
- Reset values:
  - `pcm_valid`=0, `pcm_data`=0, `pcm_ch`=0, `pcm_last`=0, `busy`=0, `overrun`=0.
  - All integrators, S, D1-D3 and `dcnt` are 0; FSM is IDLE.
- Reset asserted mid-frame aborts the drain immediately. No partial frame resumes after release.
- Latency: for a frame boundary sampled at edge T, channel 0 `pcm_valid` first rises after edge T+2 (LOAD at T+1).
- With `pcm_ready` held high, each sample takes 2 cycles, so a frame drains in 2·CH cycles.
- No-overrun requirement: DEC·(clk cycles per `pdm_en`) > 2·CH+2. At defaults this is met with `pdm_en` once every 4 clk.
- `pcm_valid` never drops without an accept, except on reset.
- A frame boundary on the same cycle as the final accept is treated as busy: the frame is dropped and `overrun` is set.

## Test plan
- All channels held at 1, `pdm_en` every 4th clk, `pcm_ready`=1: from the 4th frame onward every channel outputs 16384, `pcm_ch` runs 0..95, and `pcm_last` is high only on ch 95.
- Channel i driven with a constant (i odd → 1, even → 0): from frame 4, odd channels output +16384 and even channels −16384, with no cross-channel leakage.
- Alternating 1010… on all channels: from frame 4, all outputs are 0.
- `pcm_ready` toggled pseudo-randomly at 50% with `pdm_en` every 8 clk:
  - Outputs are stable while stalled.
  - The sequence and values match a bit-true per-channel CIC model.
  - `overrun` stays 0.
- `pdm_en` every clk with `pcm_ready`=1 (DEC=64 < 2·CH):
  - `overrun` goes 1 at the 2nd frame boundary and stays set.
  - The frame in flight completes intact.
- `rst` asserted during PRESENT of channel 40:
  - All outputs return to their reset values next cycle.
  - After release, the first emitted sample is ch 0 of a fresh frame, and results equal a cold-start reference.
